// File: rtl/uno_computer_player_n_if.sv
// Handshake/bus bundle between one computer seat and the deck/game-flow logic.
// slave = the player, master = the deck/game side driving it.
interface uno_computer_player_n_if #(
   parameter int HAND_DEPTH = 16
);
   localparam int CW = $clog2(HAND_DEPTH + 1);

   logic          i_init;
   logic          i_start;
   logic [5:0]    i_prev_card;
   logic          i_draw_two;
   logic          i_draw_four;
   logic          i_drawn;
   logic [5:0]    i_drawed_card;
   logic          i_check;
   logic          o_draw_card;
   logic [5:0]    o_out_card;
   logic          o_out;
   logic          o_pass;
   logic [CW-1:0] o_count;
   logic          o_uno;
   logic          o_win;
   logic          o_overflow;
   logic          o_busy;

   modport slave (
      input  i_init, i_start, i_prev_card, i_draw_two, i_draw_four,
             i_drawn, i_drawed_card, i_check,
      output o_draw_card, o_out_card, o_out, o_pass, o_count, o_uno,
             o_win, o_overflow, o_busy
   );

   modport master (
      output i_init, i_start, i_prev_card, i_draw_two, i_draw_four,
             i_drawn, i_drawed_card, i_check,
      input  o_draw_card, o_out_card, o_out, o_pass, o_count, o_uno,
             o_win, o_overflow, o_busy
   );
endinterface

// File: rtl/uno_computer_player_n.sv
// Computer UNO opponent: slot-based hand, draw handshake, penalty service,
// linear one-slot-per-cycle scan with priority pick and wild recolouring.
module uno_computer_player_n #(
   parameter int HAND_DEPTH  = 16,
   parameter int INIT_CARDS  = 7,
   parameter int COLOR_FIRST = 1
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   uno_computer_player_n_if.slave bus
);
   localparam int CW = $clog2(HAND_DEPTH + 1);
   localparam int IW = $clog2(HAND_DEPTH);

   typedef enum logic [3:0] {
      IDLE, INIT_REQ, INIT_WAIT, PEN_REQ, PEN_WAIT, SCAN,
      DECIDE, DRAW_REQ, DRAW_WAIT, PLAY, PASS, DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [HAND_DEPTH-1:0]      slot_vld_q, slot_vld_d;
   logic [HAND_DEPTH-1:0][5:0] slot_card_q, slot_card_d;
   logic [CW-1:0]              count_q, count_d, init_left_q, init_left_d;
   logic [2:0]                 pen_left_q, pen_left_d;
   logic [5:0]                 prev_q, prev_d, play_card_q, play_card_d;
   logic [5:0]                 out_card_q, out_card_d;
   logic [IW-1:0]              scan_idx_q, scan_idx_d, play_idx_q, play_idx_d;
   // candidate classes: [0] colour, [1] value, [2] wild, [3] wild4
   logic [3:0]                 has_q, has_d;
   logic [3:0][IW-1:0]         hit_idx_q, hit_idx_d;
   logic [3:0][CW-1:0]         tally_q, tally_d;
   logic                       start_prev_q, start_prev_d;
   logic                       out_q, out_d, pass_q, pass_d;
   logic                       win_q, win_d, ovf_q, ovf_d;

   logic          start_rise, full, drawn_ok, drawn_legal, drawn_store;
   logic          draw_req, busy;
   logic [2:0]    pen_start;
   logic [3:0]    dv, sv;
   logic [1:0]    sc, pick_col;
   logic [5:0]    scan_card;
   logic [IW-1:0] free_idx, dec_idx;

   assign start_rise = bus.i_start & ~start_prev_q;
   assign full       = (count_q == CW'(HAND_DEPTH));
   assign pen_start  = bus.i_draw_four ? 3'd4 : (bus.i_draw_two ? 3'd2 : 3'd0);
   assign dv         = bus.i_drawed_card[3:0];
   assign drawn_ok   = (dv != 4'hF);
   // a freshly drawn card is playable on colour, value (0..12) or as any wild
   assign drawn_legal = drawn_ok && ((dv == 4'd13) || (dv == 4'd14) ||
                        ((dv <= 4'd12) && ((bus.i_drawed_card[5:4] == prev_q[5:4]) ||
                                           (dv == prev_q[3:0]))));
   assign drawn_store = bus.i_drawn && drawn_ok && !full &&
                        ((state_q == INIT_WAIT) || (state_q == PEN_WAIT) ||
                         (state_q == DRAW_WAIT));
   assign scan_card  = slot_card_q[scan_idx_q];
   assign sv         = scan_card[3:0];
   assign sc         = scan_card[5:4];

   // lowest-index free slot for the next stored card
   always_comb begin
      free_idx = '0;
      for (int i = HAND_DEPTH - 1; i >= 0; i--)
         if (!slot_vld_q[i]) free_idx = IW'(i);
   end

   // wild colour: largest tally, ties (and an empty hand) go to the lowest code
   always_comb begin
      pick_col = 2'd0;
      for (int c = 1; c < 4; c++)
         if (tally_q[c] > tally_q[pick_col]) pick_col = 2'(c);
   end

   // priority pick among the candidate classes found by the scan
   always_comb begin
      dec_idx = hit_idx_q[3];
      if (has_q[2]) dec_idx = hit_idx_q[2];
      if (COLOR_FIRST != 0) begin
         if (has_q[1]) dec_idx = hit_idx_q[1];
         if (has_q[0]) dec_idx = hit_idx_q[0];
      end else begin
         if (has_q[0]) dec_idx = hit_idx_q[0];
         if (has_q[1]) dec_idx = hit_idx_q[1];
      end
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // next-state logic; i_init overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start_rise) state_d = (pen_start != 3'd0) ? PEN_REQ : SCAN;
         INIT_REQ:  state_d = full ? IDLE : INIT_WAIT;
         INIT_WAIT: if (bus.i_drawn) state_d = (init_left_q == CW'(1)) ? IDLE : INIT_REQ;
         PEN_REQ:   state_d = full ? SCAN : PEN_WAIT;
         PEN_WAIT:  if (bus.i_drawn) state_d = (pen_left_q == 3'd1) ? SCAN : PEN_REQ;
         SCAN:      if (scan_idx_q == IW'(HAND_DEPTH - 1)) state_d = DECIDE;
         DECIDE:    state_d = (|has_q) ? PLAY : DRAW_REQ;
         DRAW_REQ:  state_d = full ? PASS : DRAW_WAIT;
         DRAW_WAIT: if (bus.i_drawn) state_d = drawn_legal ? PLAY : PASS;
         PLAY:      state_d = DONE;
         PASS:      state_d = DONE;
         DONE:      if (bus.i_check) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (bus.i_init) state_d = INIT_REQ;
   end

   // state-decoded outputs: draw request is suppressed when the hand is full
   always_comb begin
      draw_req = ((state_q == INIT_REQ) || (state_q == PEN_REQ) ||
                  (state_q == DRAW_REQ)) && !full;
      busy     = (state_q != IDLE);
   end

   // datapath next values: hand storage, scan searches, play/pass pulses
   always_comb begin
      slot_vld_d   = slot_vld_q;
      slot_card_d  = slot_card_q;
      count_d      = count_q;
      init_left_d  = init_left_q;
      pen_left_d   = pen_left_q;
      prev_d       = prev_q;
      play_card_d  = play_card_q;
      play_idx_d   = play_idx_q;
      out_card_d   = out_card_q;
      scan_idx_d   = scan_idx_q;
      has_d        = has_q;
      hit_idx_d    = hit_idx_q;
      tally_d      = tally_q;
      start_prev_d = bus.i_start;
      out_d        = 1'b0;
      pass_d       = 1'b0;
      win_d        = win_q;
      ovf_d        = ovf_q;

      if (drawn_store) begin
         slot_vld_d[free_idx]  = 1'b1;
         slot_card_d[free_idx] = bus.i_drawed_card;
         count_d               = count_q + CW'(1);
      end

      case (state_q)
         IDLE: if (start_rise) begin
            prev_d     = bus.i_prev_card;
            pen_left_d = pen_start;
         end
         INIT_REQ, PEN_REQ, DRAW_REQ: if (full) ovf_d = 1'b1;
         INIT_WAIT: if (bus.i_drawn) init_left_d = init_left_q - CW'(1);
         PEN_WAIT:  if (bus.i_drawn) pen_left_d = pen_left_q - 3'd1;
         SCAN: begin
            scan_idx_d = scan_idx_q + IW'(1);
            if (slot_vld_q[scan_idx_q]) begin
               if (sv <= 4'd12) begin
                  tally_d[sc] = tally_q[sc] + CW'(1);
                  if ((sc == prev_q[5:4]) && !has_q[0]) begin
                     has_d[0] = 1'b1; hit_idx_d[0] = scan_idx_q;
                  end
                  if ((sv == prev_q[3:0]) && !has_q[1]) begin
                     has_d[1] = 1'b1; hit_idx_d[1] = scan_idx_q;
                  end
               end
               if ((sv == 4'd13) && !has_q[2]) begin
                  has_d[2] = 1'b1; hit_idx_d[2] = scan_idx_q;
               end
               if ((sv == 4'd14) && !has_q[3]) begin
                  has_d[3] = 1'b1; hit_idx_d[3] = scan_idx_q;
               end
            end
         end
         DECIDE: begin
            play_idx_d  = dec_idx;
            play_card_d = slot_card_q[dec_idx];
         end
         DRAW_WAIT: if (bus.i_drawn) begin
            play_idx_d  = free_idx;
            play_card_d = bus.i_drawed_card;
         end
         PLAY: begin
            out_d                  = 1'b1;
            out_card_d             = ((play_card_q[3:0] == 4'd13) || (play_card_q[3:0] == 4'd14)) ?
                                     {pick_col, play_card_q[3:0]} : play_card_q;
            slot_vld_d[play_idx_q] = 1'b0;
            count_d                = count_q - CW'(1);
            if (count_q == CW'(1)) win_d = 1'b1;
         end
         PASS: pass_d = 1'b1;
         default: ;
      endcase

      // fresh search state every time a scan begins
      if ((state_d == SCAN) && (state_q != SCAN)) begin
         scan_idx_d = '0;
         has_d      = '0;
         hit_idx_d  = '0;
         tally_d    = '0;
      end

      if (bus.i_init) begin
         slot_vld_d  = '0;
         count_d     = '0;
         win_d       = 1'b0;
         init_left_d = CW'(INIT_CARDS);
      end
   end

   // datapath registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         slot_vld_q   <= '0;
         slot_card_q  <= '0;
         count_q      <= '0;
         init_left_q  <= '0;
         pen_left_q   <= '0;
         prev_q       <= '0;
         play_card_q  <= '0;
         play_idx_q   <= '0;
         out_card_q   <= '0;
         scan_idx_q   <= '0;
         has_q        <= '0;
         hit_idx_q    <= '0;
         tally_q      <= '0;
         start_prev_q <= 1'b0;
         out_q        <= 1'b0;
         pass_q       <= 1'b0;
         win_q        <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         slot_vld_q   <= slot_vld_d;
         slot_card_q  <= slot_card_d;
         count_q      <= count_d;
         init_left_q  <= init_left_d;
         pen_left_q   <= pen_left_d;
         prev_q       <= prev_d;
         play_card_q  <= play_card_d;
         play_idx_q   <= play_idx_d;
         out_card_q   <= out_card_d;
         scan_idx_q   <= scan_idx_d;
         has_q        <= has_d;
         hit_idx_q    <= hit_idx_d;
         tally_q      <= tally_d;
         start_prev_q <= start_prev_d;
         out_q        <= out_d;
         pass_q       <= pass_d;
         win_q        <= win_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.o_draw_card = draw_req;
   assign bus.o_out_card  = out_card_q;
   assign bus.o_out       = out_q;
   assign bus.o_pass      = pass_q;
   assign bus.o_count     = count_q;
   assign bus.o_uno       = (count_q == CW'(1));
   assign bus.o_win       = win_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_busy      = busy;
endmodule

// File: tb/tb_uno_computer_player_n.sv
// Directed bench: seat A (16 slots, colour-first) and seat C (4 slots,
// value-first) share one stimulus set, selected by sel; a deck process
// answers every draw request from a fixed card list.
module tb_uno_computer_player_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, sel, deck_en;
   logic       t_init, t_start, t_d2, t_d4, t_drawn, t_check;
   logic [5:0] t_prev, t_card;
   logic       m_draw, m_out, m_pass, m_uno, m_win, m_ovf, m_busy;
   logic [5:0] m_card;
   logic [4:0] m_count;

   int n_vec = 0, n_bad = 0, draw_cnt = 0, dp = 0;
   logic [5:0] deck [19];

   uno_computer_player_n_if #(.HAND_DEPTH(16)) ifa ();
   uno_computer_player_n_if #(.HAND_DEPTH(4))  ifc ();

   uno_computer_player_n #(.HAND_DEPTH(16), .INIT_CARDS(7), .COLOR_FIRST(1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
   uno_computer_player_n #(.HAND_DEPTH(4), .INIT_CARDS(4), .COLOR_FIRST(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .bus(ifc));

   // route stimulus to the selected seat, idle the other
   always_comb begin
      ifa.i_init = sel ? 1'b0 : t_init;    ifc.i_init = sel ? t_init : 1'b0;
      ifa.i_start = sel ? 1'b0 : t_start;  ifc.i_start = sel ? t_start : 1'b0;
      ifa.i_draw_two = sel ? 1'b0 : t_d2;  ifc.i_draw_two = sel ? t_d2 : 1'b0;
      ifa.i_draw_four = sel ? 1'b0 : t_d4; ifc.i_draw_four = sel ? t_d4 : 1'b0;
      ifa.i_drawn = sel ? 1'b0 : t_drawn;  ifc.i_drawn = sel ? t_drawn : 1'b0;
      ifa.i_check = sel ? 1'b0 : t_check;  ifc.i_check = sel ? t_check : 1'b0;
      ifa.i_prev_card = t_prev;            ifc.i_prev_card = t_prev;
      ifa.i_drawed_card = t_card;          ifc.i_drawed_card = t_card;
      m_draw  = sel ? ifc.o_draw_card : ifa.o_draw_card;
      m_out   = sel ? ifc.o_out : ifa.o_out;
      m_pass  = sel ? ifc.o_pass : ifa.o_pass;
      m_uno   = sel ? ifc.o_uno : ifa.o_uno;
      m_win   = sel ? ifc.o_win : ifa.o_win;
      m_ovf   = sel ? ifc.o_overflow : ifa.o_overflow;
      m_busy  = sel ? ifc.o_busy : ifa.o_busy;
      m_card  = sel ? ifc.o_out_card : ifa.o_out_card;
      m_count = sel ? {2'b00, ifc.o_count} : ifa.o_count;
   end

   // deck: one cycle after a draw request, strobe the next card for one cycle
   initial begin
      bit pend;
      pend = 1'b0;
      t_drawn = 1'b0;
      t_card = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            t_drawn = 1'b1;
            t_card = (dp < 19) ? deck[dp] : 6'h0F;
            dp++;
            pend = 1'b0;
         end else begin
            t_drawn = 1'b0;
            if (m_draw && deck_en) begin
               pend = 1'b1;
               draw_cnt++;
            end
         end
      end
   end

   typedef struct {
      int prev; int d2; int d4; int ndraw; int play; int card;
      int count; int lat; int uno_b; int win;
   } turn_t;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_init(input int exp_n, input string nm);
      int k, d0;
      d0 = draw_cnt;
      @(negedge clk); t_init = 1'b1;
      @(negedge clk); t_init = 1'b0;
      k = 0;
      while (m_busy && k < 400) begin @(negedge clk); k++; end
      chk({nm, "_busy"}, int'(m_busy), 0);
      chk({nm, "_count"}, int'(m_count), exp_n);
      chk({nm, "_draws"}, draw_cnt - d0, exp_n);
      chk({nm, "_uno"}, int'(m_uno), 0);
   endtask

   task automatic run_turn(input turn_t t, input string nm);
      int k, d0;
      bit done;
      @(negedge clk);
      chk({nm, "_uno_before"}, int'(m_uno), t.uno_b);
      d0 = draw_cnt;
      t_prev = t.prev[5:0]; t_d2 = (t.d2 != 0); t_d4 = (t.d4 != 0); t_start = 1'b1;
      k = 0; done = 1'b0;
      while (!done && k < 400) begin
         @(negedge clk); k++;
         t_start = 1'b0; t_d2 = 1'b0; t_d4 = 1'b0;
         if (m_out || m_pass) done = 1'b1;
      end
      chk({nm, "_ended"}, int'(done), 1);
      chk({nm, "_played"}, int'(m_out), t.play);
      if (t.play != 0) chk({nm, "_card"}, int'(m_card), t.card);
      chk({nm, "_count"}, int'(m_count), t.count);
      chk({nm, "_draws"}, draw_cnt - d0, t.ndraw);
      chk({nm, "_win"}, int'(m_win), t.win);
      if (t.lat >= 0) chk({nm, "_latency"}, k - 1, t.lat);
      t_check = 1'b1;
      @(negedge clk);
      t_check = 1'b0;
      chk({nm, "_idle"}, int'(m_busy), 0);
   endtask

   initial begin
      turn_t ta [9];
      turn_t tc [4];
      int k;
      bit seen;
      deck = '{6'h02, 6'h14, 6'h28, 6'h3B, 6'h00, 6'h28, 6'h1E,   // A init
               6'h15, 6'h09,                                      // A single draws
               6'h0D, 6'h07, 6'h10, 6'h11,                        // A draw four
               6'h23, 6'h3C,                                      // A draw two
               6'h05, 6'h1E, 6'h25, 6'h37};                       // C init
      //        prev   d2 d4 nd pl card  cnt lat uno win
      ta[0] = '{'h11, 0, 0, 0, 1, 'h14, 6, 18, 0, 0};  // colour beats value
      ta[1] = '{'h1B, 0, 0, 0, 1, 'h3B, 5, 18, 0, 0};  // value match
      ta[2] = '{'h35, 0, 0, 0, 1, 'h0E, 4, 18, 0, 0};  // wild4, R/G tie -> red
      ta[3] = '{'h13, 0, 0, 1, 1, 'h15, 4, -1, 0, 0};  // draw, play drawn
      ta[4] = '{'h17, 0, 0, 1, 0, 'h00, 5, -1, 0, 0};  // draw, illegal -> pass
      ta[5] = '{'h30, 0, 1, 4, 1, 'h00, 8, -1, 0, 0};  // draw four then value
      ta[6] = '{'h19, 1, 0, 2, 1, 'h10, 9, -1, 0, 0};  // draw two then colour
      ta[7] = '{'h36, 0, 0, 0, 1, 'h3C, 8, 18, 0, 0};  // colour with value 12
      ta[8] = '{'h35, 0, 0, 0, 1, 'h0D, 7, 18, 0, 0};  // plain wild
      tc[0] = '{'h15, 1, 0, 0, 1, 'h05, 3, -1, 0, 0};  // full hand: penalty skipped
      tc[1] = '{'h27, 0, 0, 0, 1, 'h37, 2,  6, 0, 0};  // value beats colour
      tc[2] = '{'h05, 0, 0, 0, 1, 'h25, 1,  6, 0, 0};
      tc[3] = '{'h05, 0, 0, 0, 1, 'h0E, 0,  6, 1, 1};  // last card: empty tally, win

      rst_n = 1'b0; sel = 1'b0; deck_en = 1'b1;
      t_init = 1'b0; t_start = 1'b0; t_d2 = 1'b0; t_d4 = 1'b0; t_check = 1'b0;
      t_prev = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(m_busy), 0);
      chk("rst_count", int'(m_count), 0);
      chk("rst_card", int'(m_card), 0);
      chk("rst_draw", int'(m_draw), 0);
      rst_n = 1'b1;

      run_init(7, "a_init");
      for (int i = 0; i < 9; i++) run_turn(ta[i], $sformatf("a_turn%0d", i));
      chk("a_overflow", int'(m_ovf), 0);

      @(negedge clk); sel = 1'b1;
      run_init(4, "c_init");
      chk("c_ovf_pre", int'(m_ovf), 0);
      for (int i = 0; i < 4; i++) run_turn(tc[i], $sformatf("c_turn%0d", i));
      chk("c_overflow", int'(m_ovf), 1);
      chk("c_uno_after_win", int'(m_uno), 0);

      // reset while waiting on a penalty card
      deck_en = 1'b0;
      @(negedge clk); t_prev = 6'h05; t_d2 = 1'b1; t_start = 1'b1;
      k = 0; seen = 1'b0;
      while (!seen && k < 50) begin
         @(negedge clk); k++;
         t_start = 1'b0; t_d2 = 1'b0;
         if (m_draw) seen = 1'b1;
      end
      chk("pen_req_seen", int'(seen), 1);
      @(negedge clk);
      chk("pen_wait_busy", int'(m_busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", int'(m_busy), 0);
      chk("mid_rst_count", int'(m_count), 0);
      chk("mid_rst_win", int'(m_win), 0);
      chk("mid_rst_ovf", int'(m_ovf), 0);
      chk("mid_rst_card", int'(m_card), 0);
      chk("mid_rst_pulses", int'({m_draw, m_out, m_pass, m_uno}), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_quiet", int'({m_busy, m_draw, m_out, m_pass}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/uno_computer_player_n.md
Name: uno_computer_player_n

Overview:
Parametrised next-generation computer opponent for the DE2-115 UNO game. It keeps a hand of up to HAND_DEPTH cards in a slot register file and fills it from the deck through a draw handshake. On its turn it serves draw-two/draw-four penalties, then picks a card using a configurable match priority. It picks a colour for wild cards, and if nothing matches it draws once and plays the drawn card if legal, otherwise passes. It sits beside the deck controller and the game-flow FSM, one instance per computer seat.

Parameters:
HAND_DEPTH, 16, number of hand slots (4..32)
INIT_CARDS, 7, cards drawn on i_init (1..HAND_DEPTH)
COLOR_FIRST, 1, 1 = colour match beats value match; 0 = value match beats colour match

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock, reset is synchronous and active-low
i_init  in  1  one-cycle pulse: clear hand, then draw INIT_CARDS
i_start  in  1  turn request, level; rising edge accepted only in IDLE
i_prev_card  in  6  top of discard pile; [5:4] colour (00 R, 01 Y, 10 G, 11 B), [3:0] value
i_draw_two  in  1  penalty flag: draw 2 before playing
i_draw_four  in  1  penalty flag: draw 4 before playing
i_drawn  in  1  one-cycle strobe from deck: i_drawed_card valid
i_drawed_card  in  6  card delivered by deck
i_check  in  1  deck/game idle acknowledge; closes the turn
o_draw_card  out  1  one-cycle draw request
o_out_card  out  6  played card; wild colour bits replaced by the chosen colour
o_out  out  1  one-cycle pulse: o_out_card valid
o_pass  out  1  one-cycle pulse: turn ended without play
o_count  out  $clog2(HAND_DEPTH+1)  cards held
o_uno  out  1  o_count == 1
o_win  out  1  sticky; set when a play empties the hand
o_overflow  out  1  sticky; a draw was skipped because the hand was full
o_busy  out  1  FSM not in IDLE

Behaviour:
- Value encoding:
  - 0-9 are numbers.
  - 10 is skip, 11 is reverse, 12 is draw two.
  - 13 is wild, 14 is wild draw four; colour bits are don't-care on input.
  - 15 is invalid and is never stored.
- Reset (i_rst_n low at a clock edge): all slot valid bits 0, o_count 0, every output 0, o_out_card 6'b0, FSM IDLE. Reset mid-turn aborts the turn with no pulses.
- Hand storage: a card drawn is written to the lowest-index free slot. A played card's slot is invalidated. No compaction.
- States: IDLE, INIT_REQ, INIT_WAIT, PEN_REQ, PEN_WAIT, SCAN, DECIDE, DRAW_REQ, DRAW_WAIT, PLAY, PASS, DONE.
- i_init: accepted in any state except during reset; it has priority over i_start. It clears the hand and o_win, then runs INIT_REQ/INIT_WAIT INIT_CARDS times.
- Draw handshake:
  - *_REQ asserts o_draw_card for exactly one cycle, then moves to *_WAIT.
  - *_WAIT holds until i_drawn, stores i_drawed_card at that edge, then loops or exits.
  - i_drawn outside a WAIT state is ignored.
- Turn start: in IDLE, a rising edge of i_start latches i_prev_card and the penalty count.
  - Penalty count: 4 if i_draw_four, else 2 if i_draw_two, else 0. A draw2/draw4 level held in IDLE is latched on that same edge.
  - Penalty count > 0 goes to PEN_REQ and loops count times; 0 goes to SCAN.
- Full hand: any draw requested while o_count == HAND_DEPTH is skipped (no o_draw_card) and o_overflow is set. Remaining penalty draws are also skipped.
- SCAN: visits one slot per cycle, index 0..HAND_DEPTH-1, and runs two searches in parallel.
  - Candidate search keeps the first (lowest-index) card in each class: colour match (same colour, value ≤ 12), value match (same value ≤ 12), wild (13), wild4 (14).
  - Colour tally counts cards per colour among values ≤ 12.
  - Latency: SCAN takes exactly HAND_DEPTH cycles. DECIDE takes 1 cycle. o_out rises HAND_DEPTH+2 cycles after the accepted start or after the last penalty i_drawn.
- DECIDE picks the first available class in this order:
  - COLOR_FIRST=1: colour, value, wild, wild4.
  - COLOR_FIRST=0: value, colour, wild, wild4.
  - If a card matches both colour and value, it counts in both classes.
  - If no class has a card, go to DRAW_REQ once.
- Wild colour choice: colour with the highest tally; ties go to the lowest code. An empty tally gives red (00).
- After DRAW_WAIT the drawn card is stored, then tested against the latched prev card.
  - If it matches by colour, value, or is wild/wild4, go to PLAY with that card.
  - Otherwise go to PASS.
  - If the draw was skipped because the hand was full, go to PASS.
- PLAY:
  - o_out pulses for 1 cycle; o_out_card is registered and held until the next play or reset.
  - The slot is freed and o_count decrements.
  - If o_count reaches 0, o_win is set.
- PASS: o_pass pulses for 1 cycle.
- DONE: entered after PLAY or PASS; waits for i_check high, then goes to IDLE. i_start is ignored until IDLE is reached and a new rising edge occurs.

Test Plan:
- Init with deck sequence 000010, 010100, 101000, 111011, 000000, 101000, 011110 -> 7 o_draw_card pulses, o_count 7, slots 0-6 in draw order, o_busy drops.
- prev 010001 (Y1), COLOR_FIRST=1 -> o_out_card 010100 at start+HAND_DEPTH+2. Repeat with COLOR_FIRST=0 and prev 010000 -> 000000.
- Hand {000010, 101000, 101000, 111011}, prev 010011 -> o_pass path not taken. One draw request; deliver 010101 -> o_out_card 010101, o_count 4.
- i_draw_four with prev 110000; deliver 001101, 000111, 010000, 010001 -> 4 draws, then value match plays 010000.
- Hand {011110 only}, prev 000101 -> o_out_card 011110 recoloured to 001110 (empty tally -> red). o_win = 1, o_uno was 1 before the play.
- HAND_DEPTH=4 filled, i_draw_two -> no o_draw_card, o_overflow = 1, then scan proceeds. Reset asserted during PEN_WAIT -> all outputs 0, o_count 0.
